// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bus bundle: imem request/response, redirect, decode handoff
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  // fetch unit side
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  // environment side: memory, execute and decode
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: pc, single outstanding imem read, redirect kill
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_inst_pc;
  logic [31:0] w_inst_pc_nxt;
  logic        w_req_valid;
  logic [31:0] w_redirect_tgt;

  // targets are word aligned; the low two bits of the redirect are dropped
  assign w_redirect_tgt = bus.redirect_pc & ~32'h3;

  // a redirect suppresses the request so the stale pc is never sent
  assign w_req_valid = (r_state == S_REQ) & ~bus.redirect_valid & ~rst;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_state == S_HOLD);
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;

  // state, pc, kill flag and captured instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_inst    <= 32'h0;
      r_inst_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_kill    <= w_kill_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
    end
  end

  // next-state and datapath selection
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_kill_nxt    = r_kill;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    case (r_state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = w_redirect_tgt;
        end else if (w_req_valid && bus.imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (r_kill) begin
            // this response belongs to a fetch already redirected away;
            // a redirect landing now still updates the pc
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
            if (bus.redirect_valid) begin
              w_pc_nxt = w_redirect_tgt;
            end
          end else if (bus.redirect_valid) begin
            w_pc_nxt    = w_redirect_tgt;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_nxt    = bus.imem_rsp_data;
            w_inst_pc_nxt = r_pc;
            w_state_nxt   = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          // only one request is ever in flight, so one kill covers any
          // number of redirects before its response returns
          w_pc_nxt   = w_redirect_tgt;
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = w_redirect_tgt;
          w_state_nxt = S_REQ;
        end else if (bus.inst_ready) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed scoreboard bench for ifu_fetch
module tb_ifu_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req_addr(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, 64'(bus.imem_req_valid), 64'd1);
    if (exp_addr_q.size() == 0) begin
      chk({tag, "_addr_q_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_addr_q.pop_front();
      chk({tag, "_addr"}, 64'(bus.imem_req_addr), 64'(e));
    end
  endtask

  // Entered one time unit after a rising edge with the DUT waiting to
  // request; leaves one time unit after the edge that consumes the instruction.
  task automatic fetch_one(input logic [31:0] data, input int k, input int hold);
    logic [31:0] a;
    logic [63:0] e;
    a = exp_addr_q.size() != 0 ? exp_addr_q[0] : 32'hX;
    bus.imem_req_ready = 1'b1;
    #1;
    chk("fo_inst_valid_req", 64'(bus.inst_valid), 64'd0);
    chk_req_addr("fo_req");
    cyc();
    bus.imem_req_ready = 1'b0;
    for (int i = 1; i < k; i++) begin
      #1;
      chk("fo_wait_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("fo_wait_inst_valid", 64'(bus.inst_valid), 64'd0);
      cyc();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    exp_inst_q.push_back({data, a});
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("hold_inst_valid", 64'(bus.inst_valid), 64'd1);
      chk("hold_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("hold_inst_stable", {bus.inst, bus.inst_pc}, exp_inst_q[0]);
      cyc();
    end
    #1;
    chk("fo_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("fo_req_valid_hold", 64'(bus.imem_req_valid), 64'd0);
    if (exp_inst_q.size() == 0) begin
      chk("fo_inst_q_empty", 64'd1, 64'd0);
    end else begin
      e = exp_inst_q.pop_front();
      chk("fo_inst", {bus.inst, bus.inst_pc}, e);
    end
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] m_pc;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    #2;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'h8000_0000);
    chk("rst_addr", 64'(bus.imem_req_addr), 64'h8000_0000);
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);

    // zero-wait stream
    m_pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(m_pc);
      fetch_one(32'h0000_0013, 1, 0);
      m_pc = m_pc + 32'd4;
    end

    // decode stalls for 5 cycles
    exp_addr_q.push_back(m_pc);
    fetch_one(32'hDEAD_BEEF, 1, 5);
    m_pc = m_pc + 32'd4;

    // double redirect during WAIT, late response is dropped
    bus.imem_req_ready = 1'b1;
    #1;
    exp_addr_q.push_back(m_pc);
    chk_req_addr("kill_req");
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0203;
    cyc();
    bus.redirect_pc    = 32'h8000_0103;
    #1;
    chk("kill_req_valid_redir", 64'(bus.imem_req_valid), 64'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("kill_wait_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("kill_wait_req_valid", 64'(bus.imem_req_valid), 64'd0);
    cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("kill_dropped_inst_valid", 64'(bus.inst_valid), 64'd0);
    m_pc = 32'h8000_0100;
    exp_addr_q.push_back(m_pc);
    fetch_one(32'hA5A5_0001, 2, 0);
    m_pc = m_pc + 32'd4;

    // redirect together with the response in WAIT
    bus.imem_req_ready = 1'b1;
    #1;
    exp_addr_q.push_back(m_pc);
    chk_req_addr("rsp_redir_req");
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1111_2222;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h9000_0000;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rsp_redir_inst_valid", 64'(bus.inst_valid), 64'd0);
    m_pc = 32'h9000_0000;
    exp_addr_q.push_back(m_pc);
    chk_req_addr("rsp_redir_next");

    // redirect together with inst_ready in HOLD
    bus.imem_req_ready = 1'b1;
    #1;
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h3333_4444;
    exp_inst_q.push_back({32'h3333_4444, m_pc});
    cyc();
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("hold_redir_inst", {bus.inst, bus.inst_pc}, exp_inst_q.pop_front());
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hA000_0008;
    cyc();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("hold_redir_inst_valid", 64'(bus.inst_valid), 64'd0);
    m_pc = 32'hA000_0008;
    exp_addr_q.push_back(m_pc);
    chk_req_addr("hold_redir_next");

    // memory stall then redirect while stalled
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("stall_addr", 64'(bus.imem_req_addr), 64'(m_pc));
      cyc();
    end
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hB000_0000;
    #1;
    chk("stall_redir_req_valid", 64'(bus.imem_req_valid), 64'd0);
    cyc();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    m_pc = 32'hB000_0000;
    exp_addr_q.push_back(m_pc);
    fetch_one(32'h5555_6666, 1, 0);

    // pc wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    exp_addr_q.push_back(m_pc);
    fetch_one(32'h7777_8888, 1, 0);
    m_pc = m_pc + 32'd4;

    // reset asserted during WAIT, late response ignored
    bus.imem_req_ready = 1'b1;
    #1;
    exp_addr_q.push_back(m_pc);
    chk_req_addr("wrap_req");
    cyc();
    bus.imem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("mid_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("mid_rst_inst", {bus.inst, bus.inst_pc}, {32'h0, 32'h8000_0000});
    chk("mid_rst_addr", 64'(bus.imem_req_addr), 64'h8000_0000);
    cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hCAFE_F00D;
    cyc();
    rst = 1'b0;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("post_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    m_pc = 32'h8000_0000;
    exp_addr_q.push_back(m_pc);
    fetch_one(32'h0000_0093, 1, 0);

    chk("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    chk("inst_q_drained", 64'(exp_inst_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the NPC core. Owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, captures the returned 32-bit word, and presents it with its PC to the decode stage, where the opcode/immediate fields are split off for the immediate extender and control decoder. Accepts a redirect (jump/branch target) from execute at any time and discards stale fetches.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (always pc, low 2 bits 0)
- imem_rsp_valid  in  1  read data valid (always accepted, no ready)
- imem_rsp_data  in  32  read data
- redirect_valid  in  1  load new PC, kill current work
- redirect_pc  in  32  redirect target; bits [1:0] ignored, stored as 0
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst

## Operation
- States: REQ, WAIT, HOLD; plus 1-bit kill flag and 32-bit pc register.
- imem_req_valid = (state==REQ) & ~redirect_valid & ~rst; imem_req_addr = pc.
- REQ: redirect_valid -> pc<=redirect_pc, stay REQ (no request issued that cycle). Else req handshake (valid&ready) -> WAIT. Else stay.
- WAIT: only state that samples imem_rsp_valid.
  - rsp_valid & kill -> discard data, kill<=0, -> REQ.
  - rsp_valid & redirect_valid -> discard data, pc<=redirect_pc, kill stays 0, -> REQ.
  - rsp_valid alone -> inst<=rsp_data, inst_pc<=pc, -> HOLD.
  - redirect_valid alone -> pc<=redirect_pc, kill<=1, stay WAIT.
  - Repeated redirects in WAIT: pc takes the latest; kill stays 1; only one response is dropped.
- HOLD: inst_valid=1. redirect_valid (priority over inst_ready) -> drop inst, pc<=redirect_pc, -> REQ. Else inst_ready -> pc<=pc+4, -> REQ.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- At most one outstanding memory request; imem_rsp_valid outside WAIT is ignored.
- inst/inst_pc hold last captured values when inst_valid=0.

## Timing
- Reset (async, immediate): state=REQ, pc=RESET_PC, kill=0, inst=0, inst_pc=RESET_PC; imem_req_valid=0, inst_valid=0 while rst=1.
- First request presented in the first cycle after rst falls.
- Latency: request handshake at cycle N, response at N+k (k>=1) -> inst_valid at N+k+1.
- Zero-wait memory (ready=1, rsp next cycle): one instruction every 3 cycles with inst_ready=1.
- inst_valid, once high, stays high with stable inst/inst_pc until inst_ready or redirect.
- Redirect takes effect on the same edge; first request to new target no earlier than the following cycle.
- Reset mid-WAIT: response arriving after reset is ignored (state is REQ).

## Test plan
- Reset then ready=1, rsp 1 cycle later with 32'h0000_0013, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008; inst_valid every 3rd cycle, inst_pc matches.
- inst_ready held 0 for 5 cycles -> inst_valid high, inst/inst_pc stable, no new request; release -> next addr pc+4.
- Redirect to 32'h8000_0103 during WAIT, then rsp arrives 2 cycles later -> response dropped, no inst_valid, next req addr 8000_0100.
- Redirect coincident with rsp_valid in WAIT -> data dropped, next req addr = target; redirect coincident with inst_ready in HOLD -> redirect wins, no pc+4.
- imem_req_ready=0 for 4 cycles -> req_valid and addr held stable; redirect_valid while stalled -> req_valid 0 that cycle, then addr = new target.
- pc=32'hFFFF_FFFC accepted -> next req addr 32'h0; assert rst during WAIT -> outputs to reset values immediately, late rsp ignored, next req addr RESET_PC.
